// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg: shared FSM state encoding and reference truth tables for gate_tt_checker
package gate_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_tt_settle_timer.sv
// gate_tt_settle_timer: loadable 4-bit down-counter that holds at zero
module gate_tt_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_dec,
    input  logic [3:0] i_load_val,
    output logic [3:0] o_value,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    // load has priority over decrement; decrement stops at zero
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= 4'd0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == 4'd0);

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: walks every input pattern of a gate, compares its output to EXP_TT; GATE_TT_CAPTURE_EN adds obs_tt capture
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 2,
    parameter logic [2**N_IN-1:0]  EXP_TT = TT_AND2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_y,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] fail_idx
`ifdef GATE_TT_CAPTURE_EN
    ,
    output logic [2**N_IN-1:0] obs_tt
`endif
);

    localparam logic [3:0]  SET4    = 4'(SETTLE);
    localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

    state_t          r_state, w_next;
    logic [N_IN-1:0] r_stim;
    logic [N_IN:0]   r_err;
    logic [N_IN-1:0] r_fail;
    logic            w_load, w_dec, w_zero, w_start_ok, w_last, w_mis;
    logic [3:0]      w_cnt;

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last     = (r_stim == {N_IN{1'b1}});
    assign w_mis      = (dut_y != EXP_TT[r_stim]);

    gate_tt_settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (SET4),
        .o_value    (w_cnt),
        .o_zero     (w_zero)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // next state and timer control; WAIT spans SETTLE cycles, SAMPLE one more
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_load = start;
                w_next = start ? ((SETTLE == 0) ? ST_SAMPLE : ST_WAIT) : r_state;
            end
            ST_WAIT: begin
                w_dec  = 1'b1;
                w_next = (w_cnt == 4'd1 || w_zero) ? ST_SAMPLE : ST_WAIT;
            end
            ST_SAMPLE: begin
                w_load = !w_last;
                w_next = w_last ? ST_DONE : ((SETTLE == 0) ? ST_SAMPLE : ST_WAIT);
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // pattern stepping and mismatch bookkeeping; a new run clears results
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_stim <= '0;
            r_err  <= '0;
            r_fail <= '0;
        end else if (r_state == ST_SAMPLE) begin
            if (w_mis && r_err != ERR_MAX)
                r_err <= r_err + 1'b1;
            if (w_mis && r_err == '0)
                r_fail <= r_stim;
            r_stim <= w_last ? '0 : r_stim + 1'b1;
        end
    end

`ifdef GATE_TT_CAPTURE_EN
    logic [2**N_IN-1:0] r_obs;

    // record the sampled gate output for each pattern
    always_ff @(posedge clk) begin
        if (rst || w_start_ok)
            r_obs <= '0;
        else if (r_state == ST_SAMPLE)
            r_obs[r_stim] <= dut_y;
    end

    assign obs_tt = r_obs;
`endif

    assign stim     = r_stim;
    assign busy     = (r_state == ST_WAIT || r_state == ST_SAMPLE);
    assign done     = (r_state == ST_DONE);
    assign err_cnt  = r_err;
    assign fail_idx = r_fail;
    assign pass     = done && (r_err == '0);

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: directed and random gate runs against a truth-table reference model
module tb_gate_tt_checker;
    import gate_tt_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, start0;
    logic [3:0] r_gate, r_gate0;
    logic       dut_y, dut_y0;
    logic [1:0] stim, stim0, fail_idx, fail_idx0;
    logic       busy, done, pass, busy0, done0, pass0;
    logic [2:0] err_cnt, err_cnt0;
`ifdef GATE_TT_CAPTURE_EN
    logic [3:0] obs_tt, obs_tt0;
`endif
    int compared = 0;
    int mism = 0;

    always #5 clk = ~clk;

    assign dut_y  = r_gate[stim];
    assign dut_y0 = r_gate0[stim0];

    gate_tt_checker #(.N_IN(2), .SETTLE(2), .EXP_TT(TT_AND2)) dut (
        .clk(clk), .rst(rst), .start(start), .dut_y(dut_y), .stim(stim),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_idx(fail_idx)
`ifdef GATE_TT_CAPTURE_EN
        , .obs_tt(obs_tt)
`endif
    );

    gate_tt_checker #(.N_IN(2), .SETTLE(0), .EXP_TT(TT_XOR2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_y(dut_y0), .stim(stim0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0), .fail_idx(fail_idx0)
`ifdef GATE_TT_CAPTURE_EN
        , .obs_tt(obs_tt0)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_err(input logic [3:0] g, input logic [3:0] e);
        return $countones(g ^ e);
    endfunction

    function automatic int model_fail(input logic [3:0] g, input logic [3:0] e);
        for (int k = 0; k < 4; k++)
            if (g[k] != e[k]) return k;
        return 0;
    endfunction

    // Each loop iteration observes the values present at rising edge n (start sampled at edge 0).
    task automatic do_run(input logic [3:0] g, input bit repulse);
        int hold;
        hold = 3;
        r_gate = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            start = repulse && (n == 3 || n == 7);
            chk("busy", 8'(busy), 8'(n <= 4 * hold));
            chk("done", 8'(done), 8'(n > 4 * hold));
            chk("stim", 8'(stim), (n <= 4 * hold) ? 8'((n - 1) / hold) : 8'd0);
            @(negedge clk);
        end
        start = 1'b0;
        chk("err_cnt", 8'(err_cnt), 8'(model_err(g, TT_AND2)));
        chk("fail_idx", 8'(fail_idx), 8'(model_fail(g, TT_AND2)));
        chk("pass", 8'(pass), 8'(model_err(g, TT_AND2) == 0));
`ifdef GATE_TT_CAPTURE_EN
        chk("obs_tt", 8'(obs_tt), 8'(g));
`endif
    endtask

    task automatic do_run0(input logic [3:0] g);
        r_gate0 = g;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            chk("busy0", 8'(busy0), 8'(n <= 4));
            chk("done0", 8'(done0), 8'(n >= 5));
            chk("stim0", 8'(stim0), (n <= 4) ? 8'(n - 1) : 8'd0);
            @(negedge clk);
        end
        chk("err_cnt0", 8'(err_cnt0), 8'(model_err(g, TT_XOR2)));
        chk("fail_idx0", 8'(fail_idx0), 8'(model_fail(g, TT_XOR2)));
        chk("pass0", 8'(pass0), 8'(model_err(g, TT_XOR2) == 0));
`ifdef GATE_TT_CAPTURE_EN
        chk("obs_tt0", 8'(obs_tt0), 8'(g));
`endif
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        start0 = 1'b1;
        r_gate = TT_AND2;
        r_gate0 = TT_XOR2;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_stim", 8'(stim), 8'd0);
        chk("rst_err", 8'(err_cnt), 8'd0);
        chk("rst_fail", 8'(fail_idx), 8'd0);
        chk("rst_pass", 8'(pass), 8'd0);
        chk("rst_busy0", 8'(busy0), 8'd0);
        rst = 1'b0;
        start = 1'b0;
        start0 = 1'b0;
        @(negedge clk);
        chk("idle_busy", 8'(busy), 8'd0);
        do_run(TT_AND2, 1'b0);
        do_run(TT_OR2, 1'b0);
        do_run(4'b1111, 1'b0);
        do_run(4'b0000, 1'b0);
        do_run(TT_XOR2, 1'b1);
        // reset in the middle of a run discards all progress
        r_gate = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_err", 8'(err_cnt), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 8'(busy), 8'd0);
        chk("mrst_stim", 8'(stim), 8'd0);
        chk("mrst_err", 8'(err_cnt), 8'd0);
        chk("mrst_done", 8'(done), 8'd0);
        do_run(TT_AND2, 1'b0);
        for (int i = 0; i < 6; i++)
            do_run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        do_run0(TT_XOR2);
        do_run0(TT_NAND2);
        for (int i = 0; i < 4; i++)
            do_run0(4'($urandom_range(0, 15)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
